vend_multi_ctrl: RTL
====================

Name: vend_multi_ctrl

Overview:
- Parametrised successor to the single-product soda controller: N_PROD products, each with its own programmable price.
- Accumulates coin credit, dispenses the selected product, and returns change or refunds credit on cancel.
- Sits between the coin acceptor / keypad front-end and the per-product dispense actuators.
- One clock domain; all outputs registered.

Parameters:
- W, 8: money width in cents; credit and prices saturate at 2^W-1.
- N_PROD, 4: number of products (2..16).
- SEL_W, 2: product index width, equal to clog2(N_PROD).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- init_done  in  1  system initialisation complete.
- pb3  in  1  price-commit push-button, level.
- prg_we  in  1  price write strobe; honoured in INIT only.
- prg_sel  in  SEL_W  product index for the price write.
- prg_price  in  W  price value to write.
- c  in  1  coin-present flag; a coin is counted on its 0->1 edge.
- a  in  W  coin value, sampled on the edge of c.
- vend_req  in  1  vend request, sampled in IDLE.
- sel  in  SEL_W  product select, latched with vend_req.
- cancel  in  1  refund request.
- d  out  N_PROD  one-hot dispense pulse.
- chg_valid  out  1  change/refund pulse.
- chg  out  W  change amount; 0 when chg_valid=0.
- credit  out  W  current credit.
- busy  out  1  high whenever state != IDLE.
- err_insuff  out  1  pulse: vend refused (insufficient credit or product disabled).
- coin_rej  out  1  pulse: coin rejected on overflow.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=INIT.
  - Outputs: credit=0, d=0, chg_valid=0, chg=0, err_insuff=0, coin_rej=0, busy=1.
  - All prices=0; the c edge-detect register=0.
- Reset applied mid-operation aborts the operation. Credit is lost and no change is issued.
- States: INIT, IDLE, ADD, CHECK, DISPENSE, CHANGE.
- INIT:
  - prg_we writes price[prg_sel]=prg_price.
  - Leaves for IDLE when init_done=1 and pb3=1 at the same edge.
  - Coins, vend and cancel are ignored.
- IDLE evaluates events in this priority order:
  - c rising edge -> ADD (a latched).
  - cancel with credit>0 -> CHANGE (refund the full credit).
  - vend_req -> CHECK (sel latched).
  - cancel with credit=0 -> no action.
- Lower-priority events arriving in the same cycle are dropped. The requester must re-issue them.
- ADD (one cycle):
  - sum=credit+a computed W+1 bits wide.
  - sum<=2^W-1: credit=sum.
  - Otherwise: credit unchanged and coin_rej pulses one cycle.
  - Always returns to IDLE.
- CHECK:
  - price[sel]=0 means the product is disabled -> err_insuff pulse, go to IDLE.
  - credit>=price[sel] -> DISPENSE.
  - Otherwise err_insuff pulse, credit kept, go to IDLE.
- DISPENSE:
  - d[sel]=1 for exactly one cycle; credit=credit-price[sel].
  - Next state is CHANGE if the remainder is >0, else IDLE.
- CHANGE:
  - chg_valid=1 and chg=credit for one cycle; credit=0.
  - Next state is IDLE.
- Latency (vend_req at edge k in IDLE):
  - CHECK is active in cycle k+1.
  - d is high in cycle k+2.
  - chg_valid is high in cycle k+3.
- Latency for cancel at edge k: chg_valid is high in cycle k+2.
- Coin edge detection:
  - c held high for many cycles counts once.
  - A coin edge that arrives while busy (any state other than IDLE) is lost.
  - Upstream must hold c for at least one IDLE cycle.
- A price write to an out-of-range prg_sel (>=N_PROD) is ignored.
- INIT is re-entered only by reset.

Decomposition:
- Shared header vend_defs.vh holds:
  - state encodings (3-bit localparams);
  - default W and N_PROD;
  - coin value constants NICKEL=5, DIME=10, QUARTER=25.
- One sub-module: vend_price_table.
  - N_PROD x W register file with async active-low reset to 0.
  - Single write port gated to INIT; combinational read port indexed by the latched sel.
- The FSM, credit arithmetic and edge detect stay in vend_multi_ctrl.

Test Plan:
1. Reset, then in INIT program prices {150,75,0,200}, then init_done=1 and pb3 pulse -> state IDLE, credit=0, busy=0, all outputs 0.
2. Coins 25,25,25,10 (c toggled each coin) then vend_req with sel=1 -> credit 85; d=4'b0010 for 1 cycle at k+2; chg_valid with chg=10 at k+3; credit=0.
3. Credit 50, vend_req with sel=0 -> err_insuff 1-cycle pulse, d=0, credit stays 50. Then cancel -> chg_valid with chg=50, credit=0.
4. vend_req with sel=2 (price 0) at credit 100 -> err_insuff, no d, credit 100. Then exact-price vend with sel=3 at credit 200 -> d=4'b1000, no chg_valid, credit 0.
5. Credit 250 plus a coin of 10 -> coin_rej pulse, credit stays 250. Hold c high 20 cycles with a=5 -> credit increases by exactly 5 once.
6. Assert rst=0 during DISPENSE -> d=0, credit=0, state INIT, all prices 0 immediately, no chg_valid; coins after release are ignored until pb3.

Source files
------------

// File: rtl/vend_multi_ctrl_pkg.sv
// Shared definitions for the multi-product vending controller:
// FSM state encoding, default sizing and standard coin values.
package vend_multi_ctrl_pkg;

  // Default money width in cents and default number of products
  localparam int DEF_W      = 8;
  localparam int DEF_N_PROD = 4;

  // Standard coin values in cents
  localparam int NICKEL  = 5;
  localparam int DIME    = 10;
  localparam int QUARTER = 25;

  // Controller states, 3-bit encoding
  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_ADD      = 3'd2,
    ST_CHECK    = 3'd3,
    ST_DISPENSE = 3'd4,
    ST_CHANGE   = 3'd5
  } state_t;

endpackage

// File: rtl/vend_multi_ctrl_price_table.sv
// Per-product price register file. Prices are cleared by reset and can
// only be written while the controller is initialising; the read port is
// combinational so the FSM sees the price of the latched selection at once.
module vend_price_table
  import vend_multi_ctrl_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int N_PROD = DEF_N_PROD,
  parameter int SEL_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [W-1:0]     wr_price,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [W-1:0]     rd_price
);

  logic [W-1:0] mem [N_PROD];

  logic wr_in_range;
  logic rd_in_range;

  assign wr_in_range = int'(wr_sel) < N_PROD;
  assign rd_in_range = int'(rd_sel) < N_PROD;

  // Price storage: cleared on reset, written only for valid product indices
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_PROD; i++) begin
        mem[i] <= '0;
      end
    end else if (we && wr_in_range) begin
      mem[wr_sel] <= wr_price;
    end
  end

  // An unknown product reads as price 0, which the FSM treats as disabled
  always_comb begin
    rd_price = '0;
    if (rd_in_range) begin
      rd_price = mem[rd_sel];
    end
  end

endmodule

// File: rtl/vend_multi_ctrl.sv
// Multi-product vending controller. Accumulates coin credit, checks the
// selected product price, pulses the dispense actuator and pays out change
// or refunds. All outputs are registered.
module vend_multi_ctrl
  import vend_multi_ctrl_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int N_PROD = DEF_N_PROD,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic              pb3,
  input  logic              prg_we,
  input  logic [SEL_W-1:0]  prg_sel,
  input  logic [W-1:0]      prg_price,
  input  logic              c,
  input  logic [W-1:0]      a,
  input  logic              vend_req,
  input  logic [SEL_W-1:0]  sel,
  input  logic              cancel,
  output logic [N_PROD-1:0] d,
  output logic              chg_valid,
  output logic [W-1:0]      chg,
  output logic [W-1:0]      credit,
  output logic              busy,
  output logic              err_insuff,
  output logic              coin_rej
);

  state_t state;

  logic              c_q;
  logic              coin_edge;
  logic [W-1:0]      a_q;
  logic [SEL_W-1:0]  sel_q;
  logic [W-1:0]      price_rd;
  logic [W:0]        sum;
  logic [W-1:0]      remainder;
  logic              prg_en;
  logic              prod_disabled;
  logic              can_afford;
  logic [N_PROD-1:0] sel_onehot;

  assign coin_edge     = c & ~c_q;
  assign prg_en        = (state == ST_INIT) & prg_we;
  assign sum           = {1'b0, credit} + {1'b0, a_q};
  assign remainder     = credit - price_rd;
  assign prod_disabled = (price_rd == '0);
  assign can_afford    = (credit >= price_rd);

  vend_price_table #(
    .W      (W),
    .N_PROD (N_PROD),
    .SEL_W  (SEL_W)
  ) u_price_table (
    .clk      (clk),
    .rst      (rst),
    .we       (prg_en),
    .wr_sel   (prg_sel),
    .wr_price (prg_price),
    .rd_sel   (sel_q),
    .rd_price (price_rd)
  );

  // Dispense pattern for the latched selection; out-of-range index gives none
  always_comb begin
    sel_onehot = '0;
    if (int'(sel_q) < N_PROD) begin
      sel_onehot[sel_q] = 1'b1;
    end
  end

  // Coin-present history; tracked in every state so a coin edge seen while
  // busy is consumed and never counted later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_q <= 1'b0;
    end else begin
      c_q <= c;
    end
  end

  // Main controller: state sequencing, credit arithmetic and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_INIT;
      credit     <= '0;
      a_q        <= '0;
      sel_q      <= '0;
      d          <= '0;
      chg_valid  <= 1'b0;
      chg        <= '0;
      err_insuff <= 1'b0;
      coin_rej   <= 1'b0;
      busy       <= 1'b1;
    end else begin
      d          <= '0;
      chg_valid  <= 1'b0;
      chg        <= '0;
      err_insuff <= 1'b0;
      coin_rej   <= 1'b0;
      case (state)
        ST_INIT: begin
          if (init_done && pb3) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (coin_edge) begin
            a_q   <= a;
            state <= ST_ADD;
            busy  <= 1'b1;
          end else if (cancel && (credit != '0)) begin
            state <= ST_CHANGE;
            busy  <= 1'b1;
          end else if (vend_req) begin
            sel_q <= sel;
            state <= ST_CHECK;
            busy  <= 1'b1;
          end
        end
        ST_ADD: begin
          if (sum[W]) begin
            coin_rej <= 1'b1;
          end else begin
            credit <= sum[W-1:0];
          end
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        ST_CHECK: begin
          if (prod_disabled || !can_afford) begin
            err_insuff <= 1'b1;
            state      <= ST_IDLE;
            busy       <= 1'b0;
          end else begin
            d      <= sel_onehot;
            credit <= remainder;
            state  <= ST_DISPENSE;
            busy   <= 1'b1;
          end
        end
        ST_DISPENSE: begin
          // Change after a sale is paid on entry to CHANGE so it follows
          // the dispense pulse directly
          if (credit != '0) begin
            chg_valid <= 1'b1;
            chg       <= credit;
            credit    <= '0;
            state     <= ST_CHANGE;
            busy      <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_CHANGE: begin
          // A refund arrives here without a payout yet; after a sale the
          // payout is already on the outputs and must not repeat
          if (!chg_valid) begin
            chg_valid <= 1'b1;
            chg       <= credit;
            credit    <= '0;
          end
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_INIT;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule
